// File: rtl/dm_lane_mem.sv
// MEM-stage data memory with byte-lane stores, signed/unsigned loads, a registered
// access-error flag and a reset-triggered clear sweep. Optional store log: DM_WRITE_LOG_EN.
module dm_lane_mem #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    // Power-up contents and state match the documented simulation start.
    logic [31:0]           mem_q [DEPTH] = '{default: 32'h0};
    state_e                state_q = S_IDLE;
    state_e                state_d;
    logic [DEPTH_LOG2-1:0] ptr_q = '0;
    logic [DEPTH_LOG2-1:0] ptr_d;
    logic                  err_q = 1'b0;
    logic                  err_d;

    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic                  in_range;
    logic                  illegal;
    logic [31:0]           cur;
    logic [15:0]           half;
    logic [7:0]            byte_v;
    logic [31:0]           ld;
    logic [31:0]           wr_word;
    logic                  store_commit;
    logic                  mem_wr_en;
    logic [DEPTH_LOG2-1:0] mem_wr_idx;
    logic [31:0]           mem_wr_data;
    logic                  unused_bits;

    always_comb begin
        off      = addr - BASE_ADDR;
        idx      = off[DEPTH_LOG2+1:2];
        lane     = addr[1:0];
        in_range = (off[31:DEPTH_LOG2+2] == '0);
        illegal  = !in_range || (size == 2'b11) || (size == 2'b01 && addr[0])
                   || (size == 2'b00 && lane != 2'b00);
        cur      = mem_q[idx];
        busy     = (state_q == S_CLEAR);
    end

    // Load path: lane extraction and extension, forced to zero when not serviceable.
    always_comb begin
        half   = addr[1] ? cur[31:16] : cur[15:0];
        byte_v = cur[{lane, 3'b000} +: 8];
        case (size)
            2'b00:   ld = cur;
            2'b01:   ld = uns ? {16'h0, half} : {{16{half[15]}}, half};
            2'b10:   ld = uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            default: ld = 32'h0;
        endcase
        rdata = (busy || illegal) ? 32'h0 : ld;
    end

    // Store path: merge the selected lanes into the current word.
    always_comb begin
        wr_word = cur;
        case (size)
            2'b00: wr_word = wdata;
            2'b01: begin
                if (addr[1]) wr_word[31:16] = wdata[15:0];
                else         wr_word[15:0]  = wdata[15:0];
            end
            2'b10:   wr_word[{lane, 3'b000} +: 8] = wdata[7:0];
            default: wr_word = cur;
        endcase
        store_commit = reset && (state_q == S_IDLE) && we && !illegal;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        err_d       = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_idx  = idx;
        mem_wr_data = wr_word;
        case (state_q)
            S_CLEAR: begin
                mem_wr_en   = reset;
                mem_wr_idx  = ptr_q;
                mem_wr_data = 32'h0;
                ptr_d       = ptr_q + 1'b1;
                if (&ptr_q) state_d = S_IDLE;
            end
            default: begin
                err_d     = (we || re) && illegal;
                mem_wr_en = store_commit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr_en) mem_q[mem_wr_idx] <= mem_wr_data;
    end

    assign err = err_q;

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (store_commit)
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, wr_word);
    end
    assign unused_bits = ^off[1:0];
`else
    assign unused_bits = ^{pc, off[1:0]};
`endif

endmodule

// File: tb/tb_dm_lane_mem.sv
// Directed bench for dm_lane_mem with DEPTH_LOG2=4 (16 words) at BASE_ADDR 0.
module tb_dm_lane_mem;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h0040_0000;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    int checks = 0;
    int passes = 0;

    dm_lane_mem #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .pc(pc), .addr(addr), .we(we), .re(re),
        .size(size), .uns(uns), .wdata(wdata), .rdata(rdata), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Advance one cycle, then apply new inputs; rdata reflects them after #1,
    // err reflects the access applied in the previous call.
    task automatic cyc(input logic [31:0] a, input logic [1:0] sz, input logic u,
                       input logic w, input logic r, input logic [31:0] wd);
        @(posedge clk);
        #1;
        addr = a; size = sz; uns = u; we = w; re = r; wdata = wd;
        pc = pc + 32'd4;
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (busy !== 1'b0) $display("FAIL powerup_busy got=%b want=0", busy); else passes++;
        checks++;
        if (err !== 1'b0) $display("FAIL powerup_err got=%b want=0", err); else passes++;
        for (int i = 0; i < 16; i++) cyc(32'(i * 4), 2'b00, 1'b0, 1'b1, 1'b0, 32'hA5A5_0000 + 32'(i));
        cyc(32'h24, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'hA5A5_0009) $display("FAIL prefill got=%h want=a5a50009", rdata); else passes++;
    endtask

    task automatic test_clear_sweep;
        int n;
        int bad;
        cyc(32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_in_reset got=%b want=1", busy); else passes++;
        reset = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 16) $display("FAIL sweep_len got=%0d want=16", n); else passes++;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(32'(i * 4), 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
            if (rdata !== 32'h0) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL sweep_zero nonzero_words=%0d want=0", bad); else passes++;
    endtask

    task automatic test_word;
        cyc(32'h10, 2'b00, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
        cyc(32'h10, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h1234_5678) $display("FAIL lw got=%h want=12345678", rdata); else passes++;
        cyc(32'h13, 2'b10, 1'b1, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0000_0012) $display("FAIL lbu13 got=%h want=00000012", rdata); else passes++;
        cyc(32'h12, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0000_1234) $display("FAIL lh12 got=%h want=00001234", rdata); else passes++;
    endtask

    task automatic test_merge;
        cyc(32'h11, 2'b10, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        cyc(32'h10, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h1234_FF78) $display("FAIL sb_merge got=%h want=1234ff78", rdata); else passes++;
        cyc(32'h11, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'hFFFF_FFFF) $display("FAIL lb11 got=%h want=ffffffff", rdata); else passes++;
        cyc(32'h11, 2'b10, 1'b1, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0000_00FF) $display("FAIL lbu11 got=%h want=000000ff", rdata); else passes++;
        cyc(32'h10, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0000_0078) $display("FAIL lb10 got=%h want=00000078", rdata); else passes++;
        cyc(32'h12, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_8001);
        cyc(32'h10, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h8001_FF78) $display("FAIL sh_merge got=%h want=8001ff78", rdata); else passes++;
        cyc(32'h12, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'hFFFF_8001) $display("FAIL lh12s got=%h want=ffff8001", rdata); else passes++;
        cyc(32'h10, 2'b01, 1'b1, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0000_FF78) $display("FAIL lhu10 got=%h want=0000ff78", rdata); else passes++;
    endtask

    task automatic test_errors;
        cyc(32'h13, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_AAAA);
        cyc(32'h10, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (err !== 1'b1) $display("FAIL err_sh13 got=%b want=1", err); else passes++;
        checks++;
        if (rdata !== 32'h8001_FF78) $display("FAIL sh13_nowrite got=%h want=8001ff78", rdata); else passes++;
        cyc(32'h1000, 2'b00, 1'b0, 1'b1, 1'b1, 32'h1111_1111);
        checks++;
        if (rdata !== 32'h0) $display("FAIL oor_rdata got=%h want=00000000", rdata); else passes++;
        checks++;
        if (err !== 1'b0) $display("FAIL err_after_legal got=%b want=0", err); else passes++;
        cyc(32'h10, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (err !== 1'b1) $display("FAIL err_oor got=%b want=1", err); else passes++;
        checks++;
        if (rdata !== 32'h0) $display("FAIL size11_rdata got=%h want=00000000", rdata); else passes++;
        cyc(32'h12, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (err !== 1'b1) $display("FAIL err_size11 got=%b want=1", err); else passes++;
        checks++;
        if (rdata !== 32'h0) $display("FAIL lw_misalign_rdata got=%h want=00000000", rdata); else passes++;
        cyc(32'h10, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (err !== 1'b1) $display("FAIL err_lw_misalign got=%b want=1", err); else passes++;
        cyc(32'h13, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (err !== 1'b0) $display("FAIL err_clears got=%b want=0", err); else passes++;
        cyc(32'h10, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (err !== 1'b0) $display("FAIL err_no_access got=%b want=0", err); else passes++;
    endtask

    task automatic test_boundary;
        cyc(32'h40, 2'b00, 1'b0, 1'b1, 1'b0, 32'hBAD0_BAD0);
        cyc(32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (err !== 1'b1) $display("FAIL err_oor_edge got=%b want=1", err); else passes++;
        checks++;
        if (rdata !== 32'h0) $display("FAIL oor_no_alias got=%h want=00000000", rdata); else passes++;
        cyc(32'h3C, 2'b00, 1'b0, 1'b1, 1'b0, 32'h7654_3210);
        cyc(32'h3E, 2'b01, 1'b1, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0000_7654) $display("FAIL last_word got=%h want=00007654", rdata); else passes++;
        cyc(32'h14, 2'b00, 1'b0, 1'b1, 1'b1, 32'hCAFE_BABE);
        checks++;
        if (rdata !== 32'h0) $display("FAIL same_cycle_old got=%h want=00000000", rdata); else passes++;
        cyc(32'h14, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'hCAFE_BABE) $display("FAIL same_cycle_new got=%h want=cafebabe", rdata); else passes++;
    endtask

    task automatic test_mid_sweep_reset;
        int n;
        logic err_seen;
        cyc(32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n = 0;
        err_seen = 1'b0;
        while (busy === 1'b1 && n < 64) begin
            if (n == 10) begin
                addr = 32'h0; size = 2'b00; we = 1'b1; re = 1'b1; wdata = 32'hDEAD_BEEF;
                #1;
                checks++;
                if (rdata !== 32'h0) $display("FAIL busy_rdata got=%h want=00000000", rdata); else passes++;
            end else if (n == 12) begin
                addr = 32'h2; size = 2'b11; we = 1'b1; re = 1'b1;
            end else begin
                we = 1'b0; re = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            err_seen |= err;
        end
        we = 1'b0; re = 1'b0;
        checks++;
        if (n !== 16) $display("FAIL restart_len got=%0d want=16", n); else passes++;
        checks++;
        if (err_seen !== 1'b0) $display("FAIL busy_err got=%b want=0", err_seen); else passes++;
        cyc(32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0) $display("FAIL busy_store_ignored got=%h want=00000000", rdata); else passes++;
        cyc(32'h14, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0) $display("FAIL restart_cleared got=%h want=00000000", rdata); else passes++;
    endtask

    initial begin
        test_reset;
        test_clear_sweep;
        test_word;
        test_merge;
        test_errors;
        test_boundary;
        test_mid_sweep_reset;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
